clk_div_monitor: RTL and testbench
==================================

# clk_div_monitor

Receive-side companion to the team's divided-clock generators: samples a slow, generated waveform (`sig_in`) on the reference clock and measures its high time, low time and period in `clk` cycles. It reports each completed period and declares `locked` once the waveform has been stable for a programmable number of periods. It is used to check divider outputs (divide-by-N, duty-corrected dividers) against the expected ratio in-system and in benches.

## Interface
Parameters:
- `CNT_W`, 16: width of the high/low phase counters.
- `LOCK_COUNT`, 4: number of consecutive identical periods required to assert `locked` (≥ 2).
- `SYNC_STAGES`, 2: synchronizer depth on `sig_in` (≥ 2).

Ports:
- `clk`, input, 1: reference clock.
- `reset`, input, 1: synchronous, active-high.
- `sig_in`, input, 1: asynchronous waveform under test.
- `high_len`, output, CNT_W: cycles high in the last completed period.
- `low_len`, output, CNT_W: cycles low in the last completed period.
- `period`, output, CNT_W+1: `high_len + low_len`, full-width sum with no truncation.
- `meas_valid`, output, 1: one-cycle pulse when `high_len`, `low_len` and `period` update.
- `locked`, output, 1: level.
- `mismatch`, output, 1: one-cycle pulse when a completed period differs from the previous one.
- `timeout`, output, 1: one-cycle pulse when a phase counter saturates.

## Operation
- `sig_in` passes through a `SYNC_STAGES` flop chain, producing `s`. The registered copy `s_d` gives edge detection: `rise = s & ~s_d`, `fall = ~s & s_d`.
- State machine states: `IDLE`, `MEAS_HIGH`, `MEAS_LOW`.
- **`IDLE`**: counters are held.
  - On `rise`: `hcnt ← 1`, go to `MEAS_HIGH`.
  - The first partial period after reset is never measured.
- **`MEAS_HIGH`**:
  - While `s = 1`: `hcnt++`.
  - On `fall`: `h_cap ← hcnt`, `lcnt ← 1`, go to `MEAS_LOW`.
- **`MEAS_LOW`**:
  - While `s = 0`: `lcnt++`.
  - On `rise`: `high_len ← h_cap`, `low_len ← lcnt`, `period ← h_cap + lcnt`, `meas_valid ← 1`, `hcnt ← 1`, go to `MEAS_HIGH`.
- **Lock logic**, evaluated on each completed period:
  - If (`h_cap`, `lcnt`) equals the previously registered (`high_len`, `low_len`) and a previous period exists, `match_cnt++`, saturating at `LOCK_COUNT`.
  - Otherwise `match_cnt ← 1`, and `mismatch` pulses, but only if a previous period existed.
  - `locked = (match_cnt == LOCK_COUNT)`, registered.
  - The first completed period after reset or timeout sets `match_cnt ← 1` with no `mismatch`.
- **Saturation**: if `hcnt` or `lcnt` reaches all-ones while still counting:
  - `timeout` pulses.
  - `locked ← 0`, `match_cnt ← 0`, the previous-period history is cleared, and the state goes to `IDLE`.
  - `high_len`, `low_len` and `period` keep their last values.
- **Reset values**: all outputs 0; state `IDLE`; synchronizer flops 0; `s_d` 0.
- **Reset mid-measurement**: the partial period is discarded and no pulse is emitted.
- **Constant `sig_in`**: no `meas_valid`. `timeout` fires after 2^CNT_W − 1 cycles in the same phase, unless the block is still in `IDLE`.

## Timing
- Edge-detect latency: a `sig_in` transition is visible as `rise`/`fall` `SYNC_STAGES` cycles after the first `clk` edge that samples it.
- `meas_valid`, `high_len`, `low_len` and `period` update on the cycle after `rise` is seen in `MEAS_LOW`. Latency from the `sig_in` rise sample is `SYNC_STAGES + 1` cycles.
- `locked` and `mismatch` update in the same cycle as `meas_valid`.
- Minimum resolvable phase is 1 cycle. A glitch shorter than one `clk` period may be missed, and that is acceptable.
- `meas_valid` and `mismatch` can coincide. `timeout` never coincides with `meas_valid`.

## Structure
- Package `clk_div_monitor_pkg` holds:
  - the state enum `mon_state_t` (`IDLE`, `MEAS_HIGH`, `MEAS_LOW`);
  - the constant for the minimum `LOCK_COUNT`.
- Sub-module `sync_chain` (parameter `STAGES`, ports `clk`, `reset`, `d`, `q`) is reused by other clock-domain-crossing logic.
- All remaining logic lives in one `always_ff` plus combinational next-state logic.

## Test plan
- Reset, then `sig_in` high 3 / low 5 repeatedly (`CNT_W=16`, `LOCK_COUNT=4`):
  - first `meas_valid` reports 3 / 5 / `period` 8;
  - `locked` rises on the 4th `meas_valid`;
  - `mismatch` never pulses.
- While locked, one period of high 3 / low 6:
  - `meas_valid` reports 3 / 6 / 9, `mismatch` pulses and `locked` drops in the same cycle;
  - after returning to 3/5, `mismatch` pulses again;
  - `locked` re-asserts after 4 periods of 3/5.
- Divide-by-2 pattern, high 1 / low 1: every period reports 1 / 1 / 2 and the block locks.
- `CNT_W=4`, `sig_in` held high after a rise: `timeout` pulses after 15 cycles in `MEAS_HIGH`, `locked` = 0, state `IDLE`, last measurement retained.
- `reset` asserted mid-`MEAS_LOW` while locked:
  - next cycle all outputs are 0 with no pulses;
  - the first full period afterwards yields `meas_valid` with no `mismatch`.
- `sig_in` toggling at random phase against `clk`: the bench checks `period = high_len + low_len` on every `meas_valid`.

Source files
------------

// File: rtl/clk_div_monitor_pkg.sv
// Shared types and limits for the divided-clock monitor.
package clk_div_monitor_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    MEAS_HIGH = 2'd1,
    MEAS_LOW  = 2'd2
  } mon_state_t;

  localparam int unsigned MIN_LOCK_COUNT  = 2;
  localparam int unsigned MIN_SYNC_STAGES = 2;

endpackage

// File: rtl/sync_chain.sv
// Multi-flop synchronizer for a single asynchronous bit.
module sync_chain #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff;

  always_ff @(posedge clk) begin
    if (reset) begin
      ff <= '0;
    end else begin
      ff <= {ff[STAGES-2:0], d};
    end
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/clk_div_monitor.sv
// Measures high/low/period of a slow waveform in clk cycles and tracks lock.
module clk_div_monitor
  import clk_div_monitor_pkg::*;
#(
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned LOCK_COUNT  = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sig_in,
  output logic [CNT_W-1:0] high_len,
  output logic [CNT_W-1:0] low_len,
  output logic [CNT_W:0]   period,
  output logic             meas_valid,
  output logic             locked,
  output logic             mismatch,
  output logic             timeout
);

  localparam int unsigned LOCK_N = (LOCK_COUNT < MIN_LOCK_COUNT) ? MIN_LOCK_COUNT : LOCK_COUNT;
  localparam int unsigned SYNC_N = (SYNC_STAGES < MIN_SYNC_STAGES) ? MIN_SYNC_STAGES : SYNC_STAGES;
  localparam int unsigned MW     = $clog2(LOCK_N + 1);
  localparam int unsigned PW     = CNT_W + 1;
  localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};
  localparam logic [MW-1:0]    MATCH_FULL = MW'(LOCK_N);

  logic s, s_d, rise, fall;

  mon_state_t       state, state_nxt;
  logic [CNT_W-1:0] hcnt, hcnt_nxt, lcnt, lcnt_nxt, h_cap, h_cap_nxt;
  logic [MW-1:0]    match_cnt, match_nxt;
  logic             have_prev, have_prev_nxt;
  logic [CNT_W-1:0] high_len_nxt, low_len_nxt;
  logic [CNT_W:0]   period_nxt;
  logic             meas_valid_nxt, locked_nxt, mismatch_nxt, timeout_nxt;

  sync_chain #(.STAGES(SYNC_N)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (sig_in),
    .q     (s)
  );

  assign rise = s & ~s_d;
  assign fall = ~s & s_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      s_d        <= 1'b0;
      state      <= IDLE;
      hcnt       <= '0;
      lcnt       <= '0;
      h_cap      <= '0;
      match_cnt  <= '0;
      have_prev  <= 1'b0;
      high_len   <= '0;
      low_len    <= '0;
      period     <= '0;
      meas_valid <= 1'b0;
      locked     <= 1'b0;
      mismatch   <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      s_d        <= s;
      state      <= state_nxt;
      hcnt       <= hcnt_nxt;
      lcnt       <= lcnt_nxt;
      h_cap      <= h_cap_nxt;
      match_cnt  <= match_nxt;
      have_prev  <= have_prev_nxt;
      high_len   <= high_len_nxt;
      low_len    <= low_len_nxt;
      period     <= period_nxt;
      meas_valid <= meas_valid_nxt;
      locked     <= locked_nxt;
      mismatch   <= mismatch_nxt;
      timeout    <= timeout_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    hcnt_nxt       = hcnt;
    lcnt_nxt       = lcnt;
    h_cap_nxt      = h_cap;
    match_nxt      = match_cnt;
    have_prev_nxt  = have_prev;
    high_len_nxt   = high_len;
    low_len_nxt    = low_len;
    period_nxt     = period;
    meas_valid_nxt = 1'b0;
    locked_nxt     = locked;
    mismatch_nxt   = 1'b0;
    timeout_nxt    = 1'b0;

    case (state)
      IDLE: begin
        if (rise) begin
          hcnt_nxt  = CNT_W'(1);
          state_nxt = MEAS_HIGH;
        end
      end
      MEAS_HIGH: begin
        if (fall) begin
          h_cap_nxt = hcnt;
          lcnt_nxt  = CNT_W'(1);
          state_nxt = MEAS_LOW;
        end else if (hcnt == CNT_MAX) begin
          timeout_nxt   = 1'b1;
          locked_nxt    = 1'b0;
          match_nxt     = '0;
          have_prev_nxt = 1'b0;
          state_nxt     = IDLE;
        end else begin
          hcnt_nxt = hcnt + CNT_W'(1);
        end
      end
      MEAS_LOW: begin
        if (rise) begin
          // Period complete: publish it and compare against the previous one.
          high_len_nxt   = h_cap;
          low_len_nxt    = lcnt;
          period_nxt     = PW'(h_cap) + PW'(lcnt);
          meas_valid_nxt = 1'b1;
          hcnt_nxt       = CNT_W'(1);
          state_nxt      = MEAS_HIGH;
          have_prev_nxt  = 1'b1;
          if (have_prev && (h_cap == high_len) && (lcnt == low_len)) begin
            if (match_cnt != MATCH_FULL) begin
              match_nxt = match_cnt + MW'(1);
            end
          end else begin
            match_nxt    = MW'(1);
            mismatch_nxt = have_prev;
          end
          locked_nxt = (match_nxt == MATCH_FULL);
        end else if (lcnt == CNT_MAX) begin
          timeout_nxt   = 1'b1;
          locked_nxt    = 1'b0;
          match_nxt     = '0;
          have_prev_nxt = 1'b0;
          state_nxt     = IDLE;
        end else begin
          lcnt_nxt = lcnt + CNT_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_clk_div_monitor.sv
// Randomized and directed bench for clk_div_monitor with a period-level reference model.
module tb_clk_div_monitor;

  localparam int unsigned SYNC = 2;
  localparam int unsigned LOCK = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic sig16 = 1'b0;
  logic sig4 = 1'b0;

  logic [15:0] high16, low16;
  logic [16:0] per16;
  logic        mv16, lk16, mm16, to16;
  logic [3:0]  high4, low4;
  logic [4:0]  per4;
  logic        mv4, lk4, mm4, to4;

  int unsigned cyc = 0;
  int unsigned n_run = 0;
  int unsigned n_fail = 0;

  typedef struct {
    int unsigned cyc;
    int unsigned h;
    int unsigned l;
    bit          mis;
    bit          lock;
  } exp_t;

  exp_t expq[$];

  // Reference model state: expected outputs and run-length history of the driven waveform.
  int unsigned exp_h = 0, exp_l = 0, exp_p = 0;
  bit          exp_lock = 0;
  bit          started = 0, prev_v = 0, have_prev = 0;
  int unsigned run_h = 0, run_l = 0, last_h = 0, last_l = 0, mc = 0;

  clk_div_monitor #(.CNT_W(16), .LOCK_COUNT(LOCK), .SYNC_STAGES(SYNC)) dut16 (
    .clk        (clk),
    .reset      (reset),
    .sig_in     (sig16),
    .high_len   (high16),
    .low_len    (low16),
    .period     (per16),
    .meas_valid (mv16),
    .locked     (lk16),
    .mismatch   (mm16),
    .timeout    (to16)
  );

  clk_div_monitor #(.CNT_W(4), .LOCK_COUNT(2), .SYNC_STAGES(SYNC)) dut4 (
    .clk        (clk),
    .reset      (reset),
    .sig_in     (sig4),
    .high_len   (high4),
    .low_len    (low4),
    .period     (per4),
    .meas_valid (mv4),
    .locked     (lk4),
    .mismatch   (mm4),
    .timeout    (to4)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_run++;
    assert (got === want) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  // A period closes when the next rise is driven; its report lands SYNC+1 cycles later.
  task automatic push_period(input int unsigned h, input int unsigned l);
    bit mis;
    mis = 1'b0;
    if (have_prev && h == last_h && l == last_l) begin
      mc = (mc < LOCK) ? mc + 1 : LOCK;
    end else begin
      mis = have_prev;
      mc  = 1;
    end
    have_prev = 1'b1;
    last_h    = h;
    last_l    = l;
    expq.push_back('{cyc: cyc + SYNC + 1, h: h, l: l, mis: mis, lock: (mc == LOCK)});
  endtask

  task automatic check_cycle();
    bit   due;
    exp_t e;
    due = (expq.size() > 0) && (expq[0].cyc == cyc);
    e   = '{cyc: 0, h: 0, l: 0, mis: 1'b0, lock: 1'b0};
    if (due) begin
      e        = expq.pop_front();
      exp_h    = e.h;
      exp_l    = e.l;
      exp_p    = e.h + e.l;
      exp_lock = e.lock;
    end
    chk("meas_valid", 32'(mv16), 32'(due));
    chk("mismatch", 32'(mm16), 32'(due && e.mis));
    chk("timeout", 32'(to16), 32'd0);
    chk("locked", 32'(lk16), 32'(exp_lock));
    chk("high_len", 32'(high16), exp_h);
    chk("low_len", 32'(low16), exp_l);
    chk("period", 32'(per16), exp_p);
  endtask

  // One clk cycle: check outputs, update the model, then drive the next inputs.
  task automatic tick(input logic v, input logic v4, input logic r);
    @(negedge clk);
    check_cycle();
    if (r) begin
      expq.delete();
      exp_h = 0; exp_l = 0; exp_p = 0; exp_lock = 1'b0;
      started = 1'b0; prev_v = 1'b0; have_prev = 1'b0; mc = 0;
      run_h = 0; run_l = 0;
    end else begin
      if (v && !prev_v) begin
        if (started) push_period(run_h, run_l);
        started = 1'b1;
        run_h   = 1;
        run_l   = 0;
      end else if (started) begin
        if (v) run_h++;
        else   run_l++;
      end
      prev_v = v;
    end
    sig16 = v;
    sig4  = v4;
    reset = r;
  endtask

  task automatic send(input int unsigned h, input int unsigned l);
    repeat (h) tick(1'b1, 1'b0, 1'b0);
    repeat (l) tick(1'b0, 1'b0, 1'b0);
  endtask

  function automatic logic p4(input int i);
    return (i >= 2 && i <= 4) || (i >= 7 && i <= 9) || (i >= 12 && i <= 32) ||
           (i >= 35 && i <= 36) || (i >= 39);
  endfunction

  initial begin
    int unsigned b, h, l, seen, n_cyc, off;
    b = 0;
    seen = 0;

    tick(1'b0, 1'b0, 1'b1);
    tick(1'b0, 1'b0, 1'b1);

    // Narrow instance: lock at 3/2, hold high into saturation, then re-measure from IDLE.
    for (int i = 0; i < 45; i++) begin
      tick(1'b0, p4(i), 1'b0);
      if (i == 0) b = cyc;
      chk("t4_meas_valid", 32'(mv4), 32'(i == 10 || i == 15 || i == 42));
      chk("t4_timeout", 32'(to4), 32'(i == 30));
      chk("t4_locked", 32'(lk4), 32'(i >= 15 && i < 30));
      chk("t4_mismatch", 32'(mm4), 32'd0);
      chk("t4_high_len", 32'(high4), (i < 10) ? 32'd0 : (i < 42) ? 32'd3 : 32'd2);
      chk("t4_low_len", 32'(low4), (i < 10) ? 32'd0 : 32'd2);
      chk("t4_period", 32'(per4), (i < 10) ? 32'd0 : (i < 42) ? 32'd5 : 32'd4);
      chk("t4_cycle", cyc, b + 32'(i));
    end

    repeat (6) send(3, 5);
    send(3, 6);
    repeat (5) send(3, 5);
    repeat (8) send(1, 1);

    // Reset in the middle of a low phase while locked.
    repeat (3) tick(1'b1, 1'b0, 1'b0);
    repeat (2) tick(1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b1);
    repeat (3) tick(1'b0, 1'b0, 1'b0);
    repeat (3) send(4, 4);

    repeat (12) begin
      h = $urandom_range(1, 7);
      l = $urandom_range(1, 7);
      repeat ($urandom_range(1, 5)) send(h, l);
    end
    tick(1'b1, 1'b0, 1'b0);
    repeat (6) tick(1'b0, 1'b0, 1'b0);
    chk("drain", 32'(expq.size()), 32'd0);

    // Asynchronous toggling at random phase: only the sum relation is exact.
    for (int k = 0; k < 40; k++) begin
      n_cyc = $urandom_range(1, 6);
      off   = $urandom_range(1, 8);
      if (off >= 5) off++;
      repeat (n_cyc) begin
        @(negedge clk);
        if (mv16) begin
          seen++;
          chk("rand_sum", 32'(per16), 32'(high16) + 32'(low16));
        end
      end
      #(off) sig16 = ~sig16;
    end
    chk("rand_seen", 32'(seen > 0), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
